// File: rtl/cordic_request_arbiter.sv
// cordic_request_arbiter
//   Shares one iterative cosine CORDIC datapath between NREQ requesters.
//   Requesters are served round-robin, one transaction at a time: the chosen
//   theta is handed to the core with a start pulse. The float result goes back
//   only to the requester that issued the theta.
//
//   Optional feature macro: CORDIC_ARB_TIMEOUT_EN
//     When defined, a watchdog limits the time spent waiting for core_done to
//     TIMEOUT enabled cycles. On expiry it returns a quiet NaN and raises the
//     sticky error output.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   clk_en       global enable; registers hold while low
//   req_valid    per-requester request valid            [NREQ]
//   req_theta    packed thetas, requester i at [32*i+:32] [32*NREQ]
//   req_ready    one-hot accept strobe                  [NREQ]
//   rsp_valid    one-hot result valid                   [NREQ]
//   rsp_result   cosine result for the flagged requester [32]
//   rsp_ready    per-requester result accept            [NREQ]
//   core_start   start command to the cosine datapath
//   core_theta   captured theta driven to the datapath  [32]
//   core_done    datapath completion pulse
//   core_result  datapath result, valid with core_done  [32]
//   busy         high in any state other than IDLE
//   grant_id     current or last granted requester      [GW]
//   error        (CORDIC_ARB_TIMEOUT_EN only) sticky watchdog flag

module cordic_request_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int GW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_theta,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_result,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 core_start,
    output logic [31:0]          core_theta,
    input  logic                 core_done,
    input  logic [31:0]          core_result,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
`ifdef CORDIC_ARB_TIMEOUT_EN
    ,
    output logic                 error
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [31:0]     QNAN      = 32'h7FC00000;

    state_t          state;
    state_t          state_nx;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   winner;
    logic            win_found;
    logic [31:0]     theta_sel;
    int              idx;
    logic            accept;
    logic            done_hit;
    logic            timeout_hit;
    logic            rsp_hs;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!win_found && req_valid[GW'(idx)]) begin
                win_found = 1'b1;
                winner    = GW'(idx);
            end
        end
    end

    always_comb begin
        theta_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == GW'(i)) begin
                theta_sel = req_theta[32*i +: 32];
            end
        end
    end

    assign accept   = (state == IDLE) && clk_en && win_found;
    assign done_hit = (state == WAIT) && clk_en && core_done;
    assign rsp_hs   = (state == RESP) && clk_en && rsp_ready[grant_id];

    // req_ready is combinational from req_valid; gate it with reset so every
    // output reads 0 while reset is held.
    assign req_ready  = (accept && reset) ? (ONE_HOT_0 << winner) : '0;
    assign rsp_valid  = (state == RESP) ? (ONE_HOT_0 << grant_id) : '0;
    assign core_start = (state == ISSUE);
    assign busy       = (state != IDLE);

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;

    // wd_cnt counts WAIT cycles already spent; the TIMEOUT-th one expires.
    assign timeout_hit = (state == WAIT) && clk_en && !core_done &&
                         (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else if (clk_en) begin
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timeout_hit) begin
                error <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    // Without the watchdog, WAIT only ends on core_done.
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; every transition already qualifies on clk_en.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)                  state_nx = ISSUE;
            ISSUE:   if (clk_en)                  state_nx = WAIT;
            WAIT:    if (done_hit || timeout_hit) state_nx = RESP;
            RESP:    if (rsp_hs)                  state_nx = IDLE;
            default:                              state_nx = IDLE;
        endcase
    end

    // Transaction data: theta and grant on accept, result on completion,
    // arbitration pointer on the response handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_theta <= '0;
            grant_id   <= '0;
            rsp_result <= '0;
            last_grant <= GW'(NREQ - 1);
        end else if (clk_en) begin
            if (accept) begin
                core_theta <= theta_sel;
                grant_id   <= winner;
            end
            if (done_hit) begin
                rsp_result <= core_result;
            end else if (timeout_hit) begin
                rsp_result <= QNAN;
            end
            if (rsp_hs) begin
                last_grant <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_cordic_request_arbiter.sv
// Directed bench for cordic_request_arbiter (NREQ=4). Inputs change and
// outputs are sampled on the falling clock edge.

module tb_cordic_request_arbiter;

    localparam int NREQ = 4;
    localparam int GW   = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                clk_en = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [32*NREQ-1:0]  req_theta = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_result;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic                core_start;
    logic [31:0]         core_theta;
    logic                core_done = 1'b0;
    logic [31:0]         core_result = '0;
    logic                busy;
    logic [GW-1:0]       grant_id;
`ifdef CORDIC_ARB_TIMEOUT_EN
    logic                error;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    cordic_request_arbiter #(.NREQ(NREQ), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .req_valid   (req_valid),
        .req_theta   (req_theta),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_ready   (rsp_ready),
        .core_start  (core_start),
        .core_theta  (core_theta),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy),
        .grant_id    (grant_id)
`ifdef CORDIC_ARB_TIMEOUT_EN
        ,
        .error       (error)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] th(input int i);
        return 32'h40490FD0 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One-cycle core_done pulse after dly falling edges; returns on the
    // falling edge where the response state is visible.
    task automatic pulse_done(input logic [31:0] res, input int dly);
        repeat (dly) @(negedge clk);
        core_done   = 1'b1;
        core_result = res;
        @(negedge clk);
        core_done   = 1'b0;
        core_result = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) req_theta[32*i +: 32] = th(i);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_start", core_start, 0);
        chk("rst_theta", core_theta, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: single request from requester 0
        req_theta[31:0] = 32'h00000000;
        req_valid = 4'b0001;
        #1 chk("t1_req_ready", req_ready, 4'b0001);
        chk("t1_idle_busy", busy, 0);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("t1_start", core_start, 1);
        chk("t1_theta", core_theta, 32'h0);
        chk("t1_grant", grant_id, 0);
        chk("t1_ready_off", req_ready, 0);
        @(negedge clk);
        chk("t1_start_drop", core_start, 0);
        repeat (22) @(negedge clk);
        chk("t1_no_rsp_yet", rsp_valid, 0);
        pulse_done(32'h3F800000, 0);
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_result", rsp_result, 32'h3F800000);
        @(negedge clk);
        chk("t1_rsp_hold", rsp_valid, 4'b0001);
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = 4'b0000;
        chk("t1_back_idle", busy, 0);
        chk("t1_rsp_clear", rsp_valid, 0);
        req_theta[31:0] = th(0);

        // 2: all requesting, responses always accepted -> 0,1,2,3,0
        do_reset();
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            #1 chk("t2_req_ready", req_ready, 32'(4'b0001 << g));
            @(negedge clk);
            chk("t2_grant", grant_id, 32'(g));
            chk("t2_theta", core_theta, th(g));
            @(negedge clk);
            pulse_done(32'hBF000000 | 32'(g), 2);
            chk("t2_rsp_valid", rsp_valid, 32'(4'b0001 << g));
            chk("t2_rsp_result", rsp_result, 32'hBF000000 | 32'(g));
            @(negedge clk);
        end
        req_valid = 4'h0;
        rsp_ready = 4'h0;

        // 3: requester 1 stalls its response while others request
        do_reset();
        req_valid = 4'b0010;
        #1 chk("t3_req_ready1", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b1101;
        chk("t3_grant1", grant_id, 1);
        @(negedge clk);
        rsp_ready = 4'b1101;
        pulse_done(32'h3E99999A, 3);
        for (int k = 0; k < 5; k++) begin
            chk("t3_rsp_valid", rsp_valid, 4'b0010);
            chk("t3_rsp_stable", rsp_result, 32'h3E99999A);
            chk("t3_req_blocked", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = 4'b0000;
        #1 chk("t3_req_ready2", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        chk("t3_grant2", grant_id, 2);
        chk("t3_theta2", core_theta, th(2));
        @(negedge clk);
        pulse_done(32'h11111111, 1);
        chk("t3_rsp2", rsp_valid, 4'b0100);
        rsp_ready = 4'b0100;
        @(negedge clk);
        rsp_ready = 4'b0000;

        // 4: clk_en low in IDLE, ISSUE and WAIT
        clk_en = 1'b0;
        req_valid = 4'b0001;
        #1 chk("t4_ready_gated", req_ready, 0);
        @(negedge clk);
        chk("t4_idle_hold", busy, 0);
        clk_en = 1'b1;
        #1 chk("t4_req_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        clk_en = 1'b0;
        chk("t4_start", core_start, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_start_held", core_start, 1);
        end
        clk_en = 1'b1;
        @(negedge clk);
        chk("t4_start_drop", core_start, 0);
        clk_en = 1'b0;
        core_done = 1'b1;
        core_result = 32'hDEADBEEF;
        @(negedge clk);
        core_done = 1'b0;
        core_result = '0;
        clk_en = 1'b1;
        chk("t4_done_ignored", rsp_valid, 0);
        @(negedge clk);
        chk("t4_still_waiting", rsp_valid, 0);
        chk("t4_busy", busy, 1);
        pulse_done(32'h12345678, 1);
        chk("t4_rsp_valid", rsp_valid, 4'b0001);
        chk("t4_rsp_result", rsp_result, 32'h12345678);
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = 4'b0000;
        chk("t4_idle", busy, 0);

        // 5: reset during WAIT
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        chk("t5_grant2", grant_id, 2);
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        reset = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_grant", grant_id, 0);
        chk("t5_theta", core_theta, 0);
        chk("t5_result", rsp_result, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_start", core_start, 0);
        chk("t5_req_ready", req_ready, 0);
        req_valid = 4'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        core_done = 1'b1;
        core_result = 32'hCAFEF00D;
        @(negedge clk);
        core_done = 1'b0;
        chk("t5_late_done", rsp_valid, 0);
        chk("t5_idle", busy, 0);
        req_valid = 4'hF;
        #1 chk("t5_first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        pulse_done(32'h3F000000, 0);
        chk("t5_rsp", rsp_valid, 4'b0001);
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = 4'b0000;

`ifdef CORDIC_ARB_TIMEOUT_EN
        // 6: watchdog expiry and sticky error
        do_reset();
        chk("t6_err_rst", error, 0);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        repeat (63) @(negedge clk);
        chk("t6_not_yet", rsp_valid, 0);
        chk("t6_err_not_yet", error, 0);
        @(negedge clk);
        chk("t6_rsp_valid", rsp_valid, 4'b0001);
        chk("t6_nan", rsp_result, 32'h7FC00000);
        chk("t6_err", error, 1);
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = 4'b0000;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        pulse_done(32'h3F800000, 2);
        chk("t6_ok_rsp", rsp_valid, 4'b0010);
        chk("t6_ok_result", rsp_result, 32'h3F800000);
        chk("t6_err_sticky", error, 1);
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = 4'b0000;
        chk("t6_err_idle", error, 1);
        do_reset();
        chk("t6_err_cleared", error, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cordic_request_arbiter.md
Name: cordic_request_arbiter

Overview:
- Shares one iterative cosine CORDIC datapath between NREQ independent requesters.
- Each requester submits a single-precision theta through a valid/ready handshake.
- Round-robin arbitration picks the next requester; the block starts the core, waits for completion and returns the float result to the originating requester only.
- Sits between the requester blocks and the cosine datapath (float_to_fixed, cordic, fixed_to_float), which exposes a start/done pulse interface.

Parameters:
- NREQ, 4, number of requesters (2..8); localparam GW = $clog2(NREQ).
- TIMEOUT, 64, enabled-cycle watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- clk_en  in  1  global enable; when low, all registers hold
- req_valid  in  NREQ  per-requester request valid
- req_theta  in  32*NREQ  packed IEEE-754 theta; requester i at [32*i+31:32*i]
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  NREQ  one-hot result valid
- rsp_result  out  32  IEEE-754 cosine result for the requester flagged in rsp_valid
- rsp_ready  in  NREQ  per-requester result accept
- core_start  out  1  start command to the cosine datapath
- core_theta  out  32  captured theta driven to the datapath
- core_done  in  1  datapath completion pulse
- core_result  in  32  datapath float result, valid with core_done
- busy  out  1  high in any state other than IDLE
- grant_id  out  GW  index of the current or last granted requester

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=NREQ-1 so requester 0 wins first. All outputs are 0, including core_theta, rsp_result and grant_id.
- When clk_en=0: state, counters and data registers hold; outputs hold their values; req_ready forced 0; core_done ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g is the first i with req_valid[i], searching last_grant+1, +2, ... modulo NREQ.
  - req_ready[g]=1 combinationally when clk_en=1. The handshake completes in that cycle.
  - On completion: capture req_theta[g] into core_theta and g into grant_id; go to ISSUE.
  - No req_valid set: stay in IDLE.
- ISSUE:
  - core_start = (state==ISSUE).
  - On an enabled cycle go to WAIT. The start pulse is therefore exactly one enabled cycle wide; it stays high across clk_en=0 cycles.
- WAIT:
  - On an enabled cycle with core_done=1: capture core_result into rsp_result; go to RESP.
  - core_done in any other state is ignored.
- RESP:
  - rsp_valid[grant_id]=1; rsp_result stable.
  - On rsp_ready[grant_id]=1 with clk_en=1: last_grant=grant_id; go to IDLE. rsp_ready of other requesters is ignored.
- Latency, counted in enabled cycles:
  - Accept edge to core_start high: 1.
  - core_done to rsp_valid: 1.
  - Response handshake to next possible accept: 1.
- Only one transaction is in flight. req_ready stays 0 in every state except IDLE.
- A requester that deasserts req_valid before being accepted loses nothing; arbitration re-evaluates each IDLE cycle.
- Reset mid-transaction: the transaction is abandoned and no response is issued. A late core_done after reset release is ignored, because it arrives in IDLE.
- Arithmetic: pure data movement, no float modification. theta range checking is the datapath's responsibility.

Optional Feature:
- Macro: CORDIC_ARB_TIMEOUT_EN.
- Defined:
  - Adds output port error (1 bit) and a watchdog counter cleared on entry to WAIT, incremented on each enabled WAIT cycle.
  - If the counter reaches TIMEOUT without core_done: rsp_result=32'h7FC00000 (quiet NaN), go to RESP, set error.
  - error is sticky until reset.
- Undefined: no counter and no error port; WAIT persists indefinitely until core_done.

Test Plan:
1. req_valid=0001, theta=32'h00000000; model core_done 24 cycles after start with result 32'h3F800000 -> req_ready=0001 at cycle 0, core_start cycle 1 for one cycle with core_theta=0, rsp_valid=0001 with 32'h3F800000 one cycle after core_done.
2. req_valid=1111 held, rsp_ready tied high, each theta distinct -> grant_id sequence 0,1,2,3,0; each rsp_result is routed to the matching rsp_valid bit.
3. Requester 1 holds rsp_ready low for 5 cycles while req_valid=1101 -> rsp_valid=0010 and rsp_result held stable; req_ready stays 0000 until the handshake, then requester 2 is granted.
4. clk_en low for 3 cycles while in ISSUE -> core_start held high, state unchanged; on re-enable it drops after exactly one enabled cycle; a core_done pulse during clk_en=0 produces no response.
5. reset asserted during WAIT -> all outputs 0 immediately; a core_done pulse after release gives no rsp_valid; the next request from requester 0 is granted first.
6. CORDIC_ARB_TIMEOUT_EN defined, TIMEOUT=64, core_done never asserted -> rsp_result=32'h7FC00000 and rsp_valid after 64 enabled WAIT cycles; error=1 and remains 1 through later successful transactions until reset.
